hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 16-bit core.
- Drives stall_n/flush to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and taken-branch squashes, freezes the whole pipe during multi-cycle data-memory accesses, and drains the pipe on HLT.
- Sits beside the ID stage; its outputs connect straight to the pipeline registers' stall_n/flush inputs.

Parameters:
- DRAIN_CYCLES, 3, cycles after HLT leaves ID before halted asserts (EX, MEM, WB retire).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  4  source register 1 of the instruction in ID
- id_rt  in  4  source register 2 of the instruction in ID
- id_uses_rs  in  1  the ID instruction reads rs
- id_uses_rt  in  1  the ID instruction reads rt
- id_halt  in  1  HLT opcode in ID
- id_branch_taken  in  1  branch resolved taken in ID
- ex_rd  in  4  destination register in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_WriteReg  in  1  the EX instruction writes the register file
- mem_req  in  1  the MEM stage is issuing a data-memory access this cycle
- mem_done  in  1  data memory completes the access this cycle
- pc_wen  out  1  PC update enable
- if_id_stall_n  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID clear
- id_ex_stall_n  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX clear (bubble)
- ex_mem_stall_n  out  1  EX/MEM write enable
- mem_wb_stall_n  out  1  MEM/WB write enable
- halted  out  1  pipeline fully drained after HLT
- stall_count  out  CNT_W  saturating count of fetch-stall cycles

Behaviour:
- Reset: synchronous on rst. On reset, state=RUN, drain counter=0, stall_count=0, saved return state=RUN.
- Output values while rst=1: all stall_n=1, if_id_flush=1, id_ex_flush=1, pc_wen=0, halted=0.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are decoded combinationally from the state and inputs.
- Load-use hazard (lu): ex_mem_read & ex_WriteReg & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- mw (memory wait): mem_req & !mem_done.
- RUN, priority mw > lu > halt > branch:
  - mw: all stall_n=0, pc_wen=0, no flush. Save ret=RUN; next state MEM_WAIT.
  - lu: pc_wen=0, if_id_stall_n=0, id_ex_flush=1, id_ex_stall_n=1; EX/MEM and MEM/WB advance. Exactly one bubble per hazard; lu is re-evaluated next cycle.
  - id_halt: pc_wen=0, if_id_flush=1; HLT advances into EX. Load the counter with DRAIN_CYCLES-1; next state DRAIN.
  - id_branch_taken: pc_wen=1 (target), if_id_flush=1.
  - Otherwise: all stall_n=1, pc_wen=1, no flush.
- MEM_WAIT:
  - While !mem_done: all stall_n=0, pc_wen=0.
  - On the mem_done cycle: the pipe advances and the state returns to ret. pc_wen=1 only if ret=RUN and no lu.
  - Drain counter and all pipe contents are held throughout.
- DRAIN:
  - pc_wen=0 and if_id_flush=1 every cycle; downstream registers advance.
  - Counter decrements per advancing cycle. Reaching 0 goes to HALTED.
  - mw in DRAIN: save ret=DRAIN, go to MEM_WAIT with the counter frozen.
  - id_branch_taken and lu are ignored.
- HALTED: halted=1, all stall_n=0, pc_wen=0. Exit only via rst.
- Flush dominates stall_n on the same register; the register clears.
- stall_count: +1 per cycle with pc_wen=0 in RUN or MEM_WAIT. It saturates at all-ones and is not counted in DRAIN or HALTED.
- Reset mid-MEM_WAIT or mid-DRAIN: the next cycle is RUN with counters cleared.
- ex_rd=0 (R0) never causes a hazard.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (RUN=2'b00, MEM_WAIT=2'b01, DRAIN=2'b10, HALTED=2'b11);
  - opcode constant for HLT;
  - DRAIN_CYCLES default.
- One natural sub-module: hazard_detect, the combinational lu compare. It is reused by the forwarding unit.
- FSM, drain counter and stall counter stay in hazard_ctrl.

Test Plan:
- LW R3 in EX (ex_mem_read=1, ex_rd=3, ex_WriteReg=1), ADD in ID with id_rs=3 -> one cycle of pc_wen=0, if_id_stall_n=0, id_ex_flush=1; next cycle all stall_n=1; stall_count=1.
- Same with ex_rd=0, or with id_uses_rs=0 -> no stall, pc_wen=1.
- mem_req=1 with mem_done low for 4 cycles, then high -> all stall_n=0 for 4 cycles; cycle 5 advances; stall_count=4.
- id_halt in RUN -> if_id_flush=1 from that cycle; halted=1 after exactly DRAIN_CYCLES=3 cycles; then all stall_n=0.
- id_halt, then mem_req held 2 cycles during DRAIN -> halted delayed by 2 cycles, to cycle 5.
- lu and id_branch_taken together -> lu wins (no flush of IF/ID). rst asserted in MEM_WAIT -> next cycle RUN, stall_count=0, halted=0.
- Force stall_count to 0xFFFE, then 3 lu cycles -> count reads 0xFFFF and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage 16-bit pipeline: sequencer state encoding,
// the HLT opcode and the default drain depth.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DRAIN    = 2'b10,
        HALTED   = 2'b11
    } state_t;

    localparam logic [3:0] OP_HLT = 4'hF;

    // EX, MEM and WB must retire after HLT leaves ID.
    localparam int DRAIN_CYCLES_DEF = 3;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the ID source registers and a load in EX.
// Purely combinational; shared with the forwarding unit.
module hazard_detect (
    input  logic [3:0] id_rs_i,
    input  logic [3:0] id_rt_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    input  logic [3:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_write_reg_i,
    output logic       lu_o
);

    logic ex_load_live;
    logic rs_hit;
    logic rt_hit;

    // R0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign ex_load_live = ex_mem_read_i & ex_write_reg_i & (ex_rd_i != 4'd0);
    assign rs_hit       = id_uses_rs_i & (id_rs_i == ex_rd_i);
    assign rt_hit       = id_uses_rt_i & (id_rt_i == ex_rd_i);
    assign lu_o         = ex_load_live & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch squash, memory-wait freeze and HLT drain.
// Outputs decode combinationally from state and inputs; stall_count saturates.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             id_branch_taken,
    input  logic [3:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_WriteReg,
    input  logic             mem_req,
    input  logic             mem_done,
    output logic             pc_wen,
    output logic             if_id_stall_n,
    output logic             if_id_flush,
    output logic             id_ex_stall_n,
    output logic             id_ex_flush,
    output logic             ex_mem_stall_n,
    output logic             mem_wb_stall_n,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic mw;

    hazard_detect u_detect (
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rs_i   (id_uses_rs),
        .id_uses_rt_i   (id_uses_rt),
        .ex_rd_i        (ex_rd),
        .ex_mem_read_i  (ex_mem_read),
        .ex_write_reg_i (ex_WriteReg),
        .lu_o           (lu)
    );

    assign mw = mem_req & ~mem_done;

    always_comb begin
        pc_wen         = 1'b1;
        if_id_stall_n  = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_stall_n  = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_stall_n = 1'b1;
        mem_wb_stall_n = 1'b1;
        halted         = 1'b0;

        if (rst) begin
            pc_wen      = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mw) begin
                        pc_wen         = 1'b0;
                        if_id_stall_n  = 1'b0;
                        id_ex_stall_n  = 1'b0;
                        ex_mem_stall_n = 1'b0;
                        mem_wb_stall_n = 1'b0;
                    end else if (lu) begin
                        // Hold fetch and decode, inject one bubble into EX.
                        pc_wen        = 1'b0;
                        if_id_stall_n = 1'b0;
                        id_ex_flush   = 1'b1;
                    end else if (id_halt) begin
                        pc_wen      = 1'b0;
                        if_id_flush = 1'b1;
                    end else if (id_branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_done) begin
                        pc_wen         = 1'b0;
                        if_id_stall_n  = 1'b0;
                        id_ex_stall_n  = 1'b0;
                        ex_mem_stall_n = 1'b0;
                        mem_wb_stall_n = 1'b0;
                    end else if (ret_q == DRAIN) begin
                        pc_wen      = 1'b0;
                        if_id_flush = 1'b1;
                    end else if (lu) begin
                        pc_wen        = 1'b0;
                        if_id_stall_n = 1'b0;
                        id_ex_flush   = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_wen      = 1'b0;
                    if_id_flush = 1'b1;
                    if (mw) begin
                        if_id_stall_n  = 1'b0;
                        id_ex_stall_n  = 1'b0;
                        ex_mem_stall_n = 1'b0;
                        mem_wb_stall_n = 1'b0;
                    end
                end
                HALTED: begin
                    halted         = 1'b1;
                    pc_wen         = 1'b0;
                    if_id_stall_n  = 1'b0;
                    id_ex_stall_n  = 1'b0;
                    ex_mem_stall_n = 1'b0;
                    mem_wb_stall_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            RUN: begin
                if (mw) begin
                    ret_d   = RUN;
                    state_d = MEM_WAIT;
                end else if (!lu && id_halt) begin
                    drain_cnt_d = DW'(DRAIN_CYCLES - 1);
                    state_d     = DRAIN;
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_d = ret_q;
                end
            end
            DRAIN: begin
                if (mw) begin
                    ret_d   = DRAIN;
                    state_d = MEM_WAIT;
                end else if (drain_cnt_q <= DW'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase

        // Only fetch stalls caused by hazards or memory count; drain and halt do not.
        if ((state_q == RUN || state_q == MEM_WAIT) && !pc_wen && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: each cycle's expected controls are queued
// when inputs are applied and checked against the DUT a moment later.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_halt, id_branch_taken;
    logic        ex_mem_read, ex_WriteReg, mem_req, mem_done;
    logic        pc_wen, if_id_stall_n, if_id_flush, id_ex_stall_n, id_ex_flush;
    logic        ex_mem_stall_n, mem_wb_stall_n, halted;
    logic [15:0] stall_count;

    logic        s_pc_wen, s_ifs, s_iff, s_ids, s_idf, s_exs, s_mws, s_halted;
    logic [3:0]  s_stall_count;

    // Next-cycle stimulus; copied onto the DUT inputs at the falling edge.
    logic        n_rst;
    logic [3:0]  n_rs, n_rt, n_rd;
    logic        n_urs, n_urt, n_halt, n_br, n_mr, n_wr, n_mreq, n_mdone;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [7:0]  msk;
        logic [15:0] cnt;
        logic [3:0]  sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Control vector order: pc_wen, if_id_stall_n, if_id_flush, id_ex_stall_n,
    // id_ex_flush, ex_mem_stall_n, mem_wb_stall_n, halted.
    localparam logic [7:0] C_RUN  = 8'b1101_0110;
    localparam logic [7:0] C_LU   = 8'b0001_1110;
    localparam logic [7:0] C_FRZ  = 8'b0000_0000;
    localparam logic [7:0] C_HLT  = 8'b0111_0110;
    localparam logic [7:0] C_BR   = 8'b1111_0110;
    localparam logic [7:0] C_DFRZ = 8'b0010_0000;
    localparam logic [7:0] C_HALT = 8'b0000_0001;
    localparam logic [7:0] C_RST  = 8'b0111_1110;
    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_DRET = 8'b1000_0111;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_WriteReg(ex_WriteReg), .mem_req(mem_req), .mem_done(mem_done),
        .pc_wen(pc_wen), .if_id_stall_n(if_id_stall_n), .if_id_flush(if_id_flush),
        .id_ex_stall_n(id_ex_stall_n), .id_ex_flush(id_ex_flush),
        .ex_mem_stall_n(ex_mem_stall_n), .mem_wb_stall_n(mem_wb_stall_n),
        .halted(halted), .stall_count(stall_count)
    );

    // Narrow counter instance exercises saturation in a handful of cycles.
    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_WriteReg(ex_WriteReg), .mem_req(mem_req), .mem_done(mem_done),
        .pc_wen(s_pc_wen), .if_id_stall_n(s_ifs), .if_id_flush(s_iff),
        .id_ex_stall_n(s_ids), .id_ex_flush(s_idf),
        .ex_mem_stall_n(s_exs), .mem_wb_stall_n(s_mws),
        .halted(s_halted), .stall_count(s_stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rst = 1'b0; n_rs = 4'd0; n_rt = 4'd0; n_rd = 4'd0;
        n_urs = 1'b0; n_urt = 1'b0; n_halt = 1'b0; n_br = 1'b0;
        n_mr = 1'b0; n_wr = 1'b0; n_mreq = 1'b0; n_mdone = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] rd);
        n_mr = 1'b1; n_wr = 1'b1; n_rd = rd;
    endtask

    // cnt is the stall_count already accumulated before this cycle.
    task automatic step(input string tag, input logic [7:0] ctl, input logic [7:0] msk,
                        input int cnt);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = n_rst; id_rs = n_rs; id_rt = n_rt; ex_rd = n_rd;
        id_uses_rs = n_urs; id_uses_rt = n_urt; id_halt = n_halt; id_branch_taken = n_br;
        ex_mem_read = n_mr; ex_WriteReg = n_wr; mem_req = n_mreq; mem_done = n_mdone;
        e.tag = tag; e.ctl = ctl; e.msk = msk; e.cnt = 16'(cnt);
        e.sat = (cnt > 15) ? 4'hF : 4'(cnt);
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        chk({g.tag, "_ctl"},
            {24'd0, {pc_wen, if_id_stall_n, if_id_flush, id_ex_stall_n, id_ex_flush,
                     ex_mem_stall_n, mem_wb_stall_n, halted} & g.msk},
            {24'd0, g.ctl & g.msk});
        chk({g.tag, "_cnt"}, {16'd0, stall_count}, {16'd0, g.cnt});
        chk({g.tag, "_sat"}, {28'd0, s_stall_count}, {28'd0, g.sat});
    endtask

    initial begin
        clr();
        n_rst = 1'b1;
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_halt = 0; id_branch_taken = 0; ex_mem_read = 0; ex_WriteReg = 0;
        mem_req = 0; mem_done = 0;

        step("reset", C_RST, M_ALL, 0);
        clr();
        step("idle", C_RUN, M_ALL, 0);

        clr(); set_load(4'd3); n_rs = 4'd3; n_urs = 1'b1;
        step("lu_rs", C_LU, M_ALL, 0);
        clr();
        step("after_lu", C_RUN, M_ALL, 1);
        clr(); set_load(4'd0); n_rs = 4'd0; n_urs = 1'b1;
        step("lu_r0", C_RUN, M_ALL, 1);
        clr(); set_load(4'd3); n_rs = 4'd3; n_urs = 1'b0; n_rt = 4'd5; n_urt = 1'b1;
        step("lu_unused", C_RUN, M_ALL, 1);
        clr(); set_load(4'd7); n_rt = 4'd7; n_urt = 1'b1;
        step("lu_rt", C_LU, M_ALL, 1);
        clr(); n_wr = 1'b1; n_rd = 4'd4; n_rs = 4'd4; n_urs = 1'b1;
        step("alu_in_ex", C_RUN, M_ALL, 2);
        clr(); n_mr = 1'b1; n_rd = 4'd4; n_rs = 4'd4; n_urs = 1'b1;
        step("load_nowr", C_RUN, M_ALL, 2);
        clr(); set_load(4'd2); n_rs = 4'd2; n_urs = 1'b1; n_br = 1'b1;
        step("lu_vs_br", C_LU, M_ALL, 2);
        clr(); n_br = 1'b1;
        step("branch", C_BR, M_ALL, 3);

        clr(); n_mreq = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("mwait%0d", i), C_FRZ, M_ALL, 3 + i);
        n_mdone = 1'b1;
        step("mdone", C_RUN, M_ALL, 7);
        clr();
        step("post_mem", C_RUN, M_ALL, 7);

        clr(); n_mreq = 1'b1;
        step("mw_a", C_FRZ, M_ALL, 7);
        step("mw_b", C_FRZ, M_ALL, 8);
        n_rst = 1'b1;
        step("rst_in_mw", C_RST, M_ALL, 9);
        clr();
        step("run_after_rst", C_RUN, M_ALL, 0);

        clr(); n_halt = 1'b1;
        step("halt", C_HLT, M_ALL, 0);
        clr();
        step("drain1", C_HLT, M_ALL, 1);
        step("drain2", C_HLT, M_ALL, 1);
        step("halted", C_HALT, M_ALL, 1);
        set_load(4'd3); n_rs = 4'd3; n_urs = 1'b1; n_br = 1'b1;
        step("halted_hold", C_HALT, M_ALL, 1);

        clr(); n_rst = 1'b1;
        step("rst2", C_RST, M_ALL, 1);
        clr(); n_halt = 1'b1;
        step("halt2", C_HLT, M_ALL, 0);
        clr(); n_mreq = 1'b1;
        step("drain_mw", C_DFRZ, M_ALL, 1);
        n_mdone = 1'b1;
        step("drain_mdone", C_HLT & M_DRET, M_DRET, 1);
        clr();
        step("drain_a", C_HLT, M_ALL, 2);
        set_load(4'd6); n_rs = 4'd6; n_urs = 1'b1; n_br = 1'b1;
        step("drain_b", C_HLT, M_ALL, 2);
        clr();
        step("halted2", C_HALT, M_ALL, 2);

        n_rst = 1'b1;
        step("rst3", C_RST, M_ALL, 2);
        clr(); set_load(4'd9); n_rs = 4'd9; n_urs = 1'b1;
        for (int i = 0; i < 17; i++) step($sformatf("sat%0d", i), C_LU, M_ALL, i);
        clr();
        step("sat_hold", C_RUN, M_ALL, 17);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
